input_conditioner: RTL

// - Front end between raw board buttons/switches and the clock control FSM; produces its adj, sel, pause_tog inputs.
// - Per channel: N-flop synchroniser, then a counter debouncer.
// - Switch channels (adj, sel) give clean levels; button channels (pause, reset) give one-cycle pulses on press.

---
 rtl/input_conditioner_if.sv | 22 ++
 rtl/input_conditioner.sv | 88 ++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned control outputs of the input conditioner.
// master drives the raw side, slave is the conditioner itself.
interface input_conditioner_if;
  logic sw_adj;
  logic sw_sel;
  logic btn_pause;
  logic btn_rst;
  logic adj;
  logic sel;
  logic pause_tog;
  logic rst_req;

  modport master (
    output sw_adj, sw_sel, btn_pause, btn_rst,
    input  adj, sel, pause_tog, rst_req
  );

  modport slave (
    input  sw_adj, sw_sel, btn_pause, btn_rst,
    output adj, sel, pause_tog, rst_req
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchroniser + counter debouncer for switches (levels) and buttons (pulses).
// Optional PAUSE_MASK_IN_ADJ_EN suppresses pause_tog while adj is high.
module input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   io
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // channel order: 0 adj, 1 sel, 2 pause, 3 rst
  logic [3:0]             raw;
  logic [3:0]             s;
  logic [3:0]             deb_q;
  logic [3:0]             deb_n;
  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [CNT_W-1:0]       cnt_q  [4];
  logic [CNT_W-1:0]       cnt_n  [4];
  logic                   e_pause;
  logic                   e_rst;
  logic                   pause_q;
  logic                   rst_req_q;
  logic                   pause_rise;

  assign raw = {io.btn_rst, io.btn_pause, io.sw_sel, io.sw_adj};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    deb_n = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_n[i] = '0;
      if (s[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_n[i] = s[i];
        end else begin
          cnt_n[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef PAUSE_MASK_IN_ADJ_EN
  // gate on both current and next adj so the pulse never overlaps adj=1
  assign pause_rise = deb_q[2] & ~e_pause & ~deb_q[0] & ~deb_n[0];
`else
  assign pause_rise = deb_q[2] & ~e_pause;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      deb_q     <= '0;
      e_pause   <= 1'b0;
      e_rst     <= 1'b0;
      pause_q   <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        cnt_q[i]  <= cnt_n[i];
      end
      deb_q     <= deb_n;
      e_pause   <= deb_q[2];
      e_rst     <= deb_q[3];
      pause_q   <= pause_rise;
      rst_req_q <= deb_q[3] & ~e_rst;
    end
  end

  assign io.adj       = deb_q[0];
  assign io.sel       = deb_q[1];
  assign io.pause_tog = pause_q;
  assign io.rst_req   = rst_req_q;

endmodule
